pipemem_stage: RTL



---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipemem_align.sv | 64 ++++++
 rtl/pipemem_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the MEM stage of the MIPS32 pipeline.
//   SZ_*      : access size field, mfunc[1:0]
//   MFUNC_UNS : mfunc bit selecting zero-extension of loads
//   state_t   : MEM-stage bus FSM states
package pipe_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MFUNC_UNS = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipemem_align.sv
// Byte-lane steering for the MEM stage (purely combinational).
//   size       in  access size (11 treated as word)
//   uns        in  zero-extend loads when set
//   addr       in  low two bits of the byte address
//   mb         in  right-justified store data
//   mem_rdata  in  raw bus read word
//   be         out byte enables, bit i = lane i
//   wdata      out store data replicated across lanes
//   load_val   out extended load value
//   misaligned out access violates its natural alignment
module pipemem_align
    import pipe_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr,
    input  logic [31:0] mb,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Addressed lanes of the read word
    always_comb begin
        byte_lane = mem_rdata[7:0];
        case (addr)
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            2'd3:    byte_lane = mem_rdata[31:24];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    // Enables, store replication, load extension and alignment per size
    always_comb begin
        be         = 4'b1111;
        wdata      = mb;
        load_val   = mem_rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << addr;
                wdata    = {4{mb[7:0]}};
                load_val = uns ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                misaligned = addr[0];
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata      = {2{mb[15:0]}};
                load_val   = uns ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/pipemem_stage.sv
// MEM stage: drives the data-memory req/ready bus, formats load data
// for MEM/WB, stalls upstream while memory is slow, flags misaligned
// accesses and bus timeouts.
//   clock, resetn        clock and synchronous active-low reset
//   mwmem, mm2reg        store / load in MEM (both set = store)
//   mfunc, malu, mb      size+unsigned, byte address, store data
//   mmo                  formatted load data
//   mstall               freeze upstream, bubble into MEM/WB
//   mexc_align           misaligned access this cycle
//   mexc_berr            bus timeout, one-cycle pulse
//   mem_*                data-memory bus
module pipemem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [2:0]  mfunc,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        mexc_align,
    output logic        mexc_berr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               access;
    logic               is_load;
    logic               timeout;
    logic [3:0]         be;
    logic [31:0]        load_val;
    logic               misaligned;

    assign access  = mwmem | mm2reg;
    assign is_load = mm2reg & ~mwmem;
    // The request cycle in IDLE is the first cycle without ready, so the
    // error fires once the WAIT count shows TIMEOUT-1 ready-less cycles.
    assign timeout = (cnt == CNT_W'(TIMEOUT - 2));

    pipemem_align u_align (
        .size       (mfunc[1:0]),
        .uns        (mfunc[MFUNC_UNS]),
        .addr       (malu[1:0]),
        .mb         (mb),
        .mem_rdata  (mem_rdata),
        .be         (be),
        .wdata      (mem_wdata),
        .load_val   (load_val),
        .misaligned (misaligned)
    );

    // State and wait counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (access && !misaligned && !mem_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready || timeout) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Bus handshake, stall and load formatting
    always_comb begin
        mem_req    = 1'b0;
        mstall     = 1'b0;
        mexc_berr  = 1'b0;
        mmo        = '0;
        mexc_align = access & misaligned;
        mem_addr   = {malu[31:2], 2'b00};
        case (state)
            ST_IDLE: begin
                if (access && !misaligned) begin
                    mem_req = 1'b1;
                    mstall  = ~mem_ready;
                    if (mem_ready && is_load) begin
                        mmo = load_val;
                    end
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if (is_load) begin
                        mmo = load_val;
                    end
                end else if (timeout) begin
                    mexc_berr = 1'b1;
                end else begin
                    mstall = 1'b1;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        mem_we = mem_req & mwmem;
        mem_be = mem_req ? be : 4'b0000;
    end

endmodule
